// File: rtl/pushbutton_array_processor_pkg.sv
// -----------------------------------------------------------------------------
// pushbutton_array_processor_pkg
// Shared definitions for the pushbutton array processor. The testbench uses
// these definitions too.
//   MAX_BUTTONS  : upper bound on the number of channels the array supports
//   btn_state_e  : per-channel press classifier state encoding
// -----------------------------------------------------------------------------
package pushbutton_array_processor_pkg;

    localparam int MAX_BUTTONS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_LONG  = 2'd2
    } btn_state_e;

endpackage

// File: rtl/pushbutton_array_processor_channel.sv
// -----------------------------------------------------------------------------
// pushbutton_array_processor_channel
// One pushbutton channel. It contains a 2-flop synchroniser, a mismatch-count
// debouncer and a short/long/repeat press classifier.
//   clk_1khz     : 1 kHz clock, rising edge
//   rst_n        : async active-low reset (already release-synchronised)
//   pushbutton_i : raw asynchronous button, active-high
//   repeat_en    : auto-repeat enable while a long press is held
//   count_up     : one-cycle pulse per short press
//   count_down   : one-cycle pulse per long press and per repeat tick
//   pressed_o    : debounced button level
// -----------------------------------------------------------------------------
module pushbutton_array_processor_channel
    import pushbutton_array_processor_pkg::*;
#(
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 2000,
    parameter int REPEAT_MS     = 250
) (
    input  logic clk_1khz,
    input  logic rst_n,
    input  logic pushbutton_i,
    input  logic repeat_en,
    output logic count_up,
    output logic count_down,
    output logic pressed_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_MS + 1);
    localparam int REP_W  = $clog2(REPEAT_MS + 1);

    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_MS);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1'b1);
    localparam logic [DB_W-1:0]   DB_ZERO   = {DB_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_MS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REPEAT_MS);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1'b1);
    localparam logic [REP_W-1:0]  REP_ZERO  = {REP_W{1'b0}};

    logic              sync1_r;
    logic              sync2_r;
    logic              pressed_r;
    logic [DB_W-1:0]   db_cnt_r;
    logic [DB_W-1:0]   db_inc_s;
    btn_state_e        state_r;
    btn_state_e        state_n_s;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_n_s;
    logic [HOLD_W-1:0] hold_inc_s;
    logic [REP_W-1:0]  rep_r;
    logic [REP_W-1:0]  rep_n_s;
    logic [REP_W-1:0]  rep_inc_s;
    logic              up_n_s;
    logic              dn_n_s;
    logic              count_up_r;
    logic              count_down_r;

    // Counters saturate at their terminal value instead of wrapping.
    assign db_inc_s   = (db_cnt_r == DB_MAX)  ? db_cnt_r : db_cnt_r + DB_ONE;
    assign hold_inc_s = (hold_r   == HOLD_MAX) ? hold_r  : hold_r + HOLD_ONE;
    assign rep_inc_s  = (rep_r    == REP_MAX)  ? rep_r   : rep_r + REP_ONE;

    // Two-flop synchroniser for the raw button input
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pushbutton_i;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: the level flips only after DEBOUNCE_MS consecutive mismatching samples
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r  <= DB_ZERO;
            pressed_r <= 1'b0;
        end else if (sync2_r != pressed_r) begin
            if (db_inc_s == DB_MAX) begin
                pressed_r <= ~pressed_r;
                db_cnt_r  <= DB_ZERO;
            end else begin
                db_cnt_r  <= db_inc_s;
            end
        end else begin
            db_cnt_r <= DB_ZERO;
        end
    end

    // Press classifier next-state and pulse decode. It works on the registered
    // debounced level, so a release is seen one cycle after pressed_o falls.
    always_comb begin
        state_n_s = state_r;
        hold_n_s  = hold_r;
        rep_n_s   = rep_r;
        up_n_s    = 1'b0;
        dn_n_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                hold_n_s = HOLD_ZERO;
                if (pressed_r) begin
                    state_n_s = ST_PRESS;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_PRESS: begin
                if (!pressed_r) begin
                    up_n_s    = (hold_r < HOLD_MAX);
                    state_n_s = ST_IDLE;
                end else if (hold_inc_s == HOLD_MAX) begin
                    dn_n_s    = 1'b1;
                    hold_n_s  = hold_inc_s;
                    rep_n_s   = REP_ZERO;
                    state_n_s = ST_LONG;
                end else begin
                    hold_n_s  = hold_inc_s;
                end
            end
            ST_LONG: begin
                if (!pressed_r) begin
                    state_n_s = ST_IDLE;
                end else if (!repeat_en) begin
                    rep_n_s = REP_ZERO;
                end else if (rep_inc_s == REP_MAX) begin
                    dn_n_s  = 1'b1;
                    rep_n_s = REP_ZERO;
                end else begin
                    rep_n_s = rep_inc_s;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                hold_n_s  = HOLD_ZERO;
                rep_n_s   = REP_ZERO;
            end
        endcase
    end

    // Classifier state, counters and registered output pulses
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            hold_r       <= HOLD_ZERO;
            rep_r        <= REP_ZERO;
            count_up_r   <= 1'b0;
            count_down_r <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            hold_r       <= hold_n_s;
            rep_r        <= rep_n_s;
            count_up_r   <= up_n_s;
            count_down_r <= dn_n_s;
        end
    end

    assign count_up   = count_up_r;
    assign count_down = count_down_r;
    assign pressed_o  = pressed_r;

endmodule

// File: rtl/pushbutton_array_processor.sv
// -----------------------------------------------------------------------------
// pushbutton_array_processor
// An array of N_BUTTONS independent pushbutton channels. The channels share
// one reset whose release is synchronised to the clock.
//   clk_1khz     : 1 kHz clock, rising edge
//   rst_n        : async active-low reset
//   pushbutton_i : raw buttons, bit k = channel k
//   repeat_en    : global auto-repeat enable
//   count_up     : short-press pulses, per channel
//   count_down   : long-press / repeat pulses, per channel
//   pressed_o    : debounced levels, per channel
// -----------------------------------------------------------------------------
module pushbutton_array_processor
    import pushbutton_array_processor_pkg::*;
#(
    parameter int N_BUTTONS     = 2,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 2000,
    parameter int REPEAT_MS     = 250
) (
    input  logic                 clk_1khz,
    input  logic                 rst_n,
    input  logic [N_BUTTONS-1:0] pushbutton_i,
    input  logic                 repeat_en,
    output logic [N_BUTTONS-1:0] count_up,
    output logic [N_BUTTONS-1:0] count_down,
    output logic [N_BUTTONS-1:0] pressed_o
);

    logic rst_meta_r;
    logic rst_sync_r;

    // Reset synchroniser: assertion is immediate, release takes two clock edges
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    for (genvar k = 0; k < N_BUTTONS; k++) begin : g_ch
        pushbutton_array_processor_channel #(
            .DEBOUNCE_MS   (DEBOUNCE_MS),
            .LONG_PRESS_MS (LONG_PRESS_MS),
            .REPEAT_MS     (REPEAT_MS)
        ) u_pushbutton_channel (
            .clk_1khz     (clk_1khz),
            .rst_n        (rst_sync_r),
            .pushbutton_i (pushbutton_i[k]),
            .repeat_en    (repeat_en),
            .count_up     (count_up[k]),
            .count_down   (count_down[k]),
            .pressed_o    (pressed_o[k])
        );
    end

endmodule
